// File: rtl/iopmp_check_arbiter.sv
// rtl/iopmp_check_arbiter.sv - round-robin arbiter sharing one IOPMP checker among request channels
module iopmp_check_arbiter #(
    parameter int NumChan       = 2,
    parameter int AddrWidth     = 34,
    parameter int RridWidth     = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumChan-1:0]           req_valid_i,
    output logic [NumChan-1:0]           req_ready_o,
    input  logic [NumChan*AddrWidth-1:0] req_addr_i,
    input  logic [NumChan*2-1:0]         req_access_i,
    output logic [NumChan-1:0]           rsp_valid_o,
    output logic                         rsp_denied_o,
    output logic                         rsp_timeout_o,
    input  logic [NumChan-1:0]           rsp_ack_i,
    output logic                         chk_valid_o,
    output logic [AddrWidth-1:0]         chk_addr_o,
    output logic [1:0]                   chk_access_o,
    output logic [RridWidth-1:0]         chk_rrid_o,
    input  logic                         chk_done_i,
    input  logic                         chk_denied_i,
    output logic                         busy_o
);
    localparam int IdxW = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, grant_q, grant_next;
    logic [CntW-1:0]       cnt_q;
    logic                  denied_q, timeout_q;

    logic [NumChan-1:0]    req_rot;
    logic                  arb_found;
    logic [IdxW-1:0]       arb_off, arb_idx;
    logic [IdxW:0]         arb_sum;
    logic [AddrWidth-1:0]  addr_sel;
    logic [1:0]            acc_sel;
    logic                  ack_hit, timeout_hit;

    // Rotating the request vector by rr_ptr makes the lowest set bit the round-robin winner.
    assign req_rot = NumChan'({req_valid_i, req_valid_i} >> rr_ptr_q);

    always_comb begin
        arb_found = 1'b0;
        arb_off   = '0;
        for (int i = NumChan - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_found = 1'b1;
                arb_off   = IdxW'(i);
            end
        end
        arb_sum = {1'b0, rr_ptr_q} + {1'b0, arb_off};
        arb_idx = (arb_sum >= (IdxW+1)'(NumChan)) ? IdxW'(arb_sum - (IdxW+1)'(NumChan))
                                                 : IdxW'(arb_sum);
    end

    always_comb begin
        addr_sel = '0;
        acc_sel  = '0;
        for (int c = 0; c < NumChan; c++) begin
            if (arb_idx == IdxW'(c)) begin
                addr_sel = req_addr_i[c*AddrWidth +: AddrWidth];
                acc_sel  = req_access_i[c*2 +: 2];
            end
        end
    end

    assign grant_next  = (grant_q == IdxW'(NumChan - 1)) ? '0 : grant_q + 1'b1;
    assign timeout_hit = (cnt_q == CntLast);
    assign ack_hit     = |(rsp_ack_i & rsp_valid_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        rsp_denied_o  = 1'b0;
        rsp_timeout_o = 1'b0;
        chk_valid_o   = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    req_ready_o = NumChan'(1) << arb_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                chk_valid_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (chk_done_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o   = NumChan'(1) << grant_q;
                rsp_denied_o  = denied_q;
                rsp_timeout_o = timeout_q;
                if (ack_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            denied_q     <= 1'b0;
            timeout_q    <= 1'b0;
            chk_addr_o   <= '0;
            chk_access_o <= '0;
            chk_rrid_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        grant_q      <= arb_idx;
                        chk_addr_o   <= addr_sel;
                        chk_access_o <= acc_sel;
                        chk_rrid_o   <= RridWidth'(arb_idx);
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A result arriving on the final cycle takes priority over the timeout.
                    if (chk_done_i) begin
                        denied_q  <= chk_denied_i;
                        timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        denied_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (ack_hit) begin
                        rr_ptr_q <= grant_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// tb/tb_iopmp_check_arbiter.sv - self-checking bench for iopmp_check_arbiter
module tb_iopmp_check_arbiter;
    localparam int NC = 2;
    localparam int AW = 34;
    localparam int RW = 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     req_valid_i = '0;
    logic [NC-1:0]     req_ready_o;
    logic [NC*AW-1:0]  req_addr_i = '0;
    logic [NC*2-1:0]   req_access_i = '0;
    logic [NC-1:0]     rsp_valid_o;
    logic              rsp_denied_o, rsp_timeout_o;
    logic [NC-1:0]     rsp_ack_i = '0;
    logic              chk_valid_o;
    logic [AW-1:0]     chk_addr_o;
    logic [1:0]        chk_access_o;
    logic [RW-1:0]     chk_rrid_o;
    logic              chk_done_i = 1'b0;
    logic              chk_denied_i = 1'b0;
    logic              busy_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int done_delay  = 0;
    bit done_denied = 1'b0;
    int ack_delay   = 0;
    int done_timer  = 0;
    int resp_cycles = 0;

    bit            m_active, m_resolved, m_denied, m_timeout;
    int            m_owner, m_age, m_rr;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_acc;

    iopmp_check_arbiter #(
        .NumChan(NC), .AddrWidth(AW), .RridWidth(RW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_access_i(req_access_i),
        .rsp_valid_o(rsp_valid_o), .rsp_denied_o(rsp_denied_o),
        .rsp_timeout_o(rsp_timeout_o), .rsp_ack_i(rsp_ack_i),
        .chk_valid_o(chk_valid_o), .chk_addr_o(chk_addr_o),
        .chk_access_o(chk_access_o), .chk_rrid_o(chk_rrid_o),
        .chk_done_i(chk_done_i), .chk_denied_i(chk_denied_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction tracked by its age since acceptance.
    initial begin
        logic [NC-1:0] exp_ready, exp_rsp;
        bit            found;
        int            pick, c;
        m_active = 0; m_resolved = 0; m_denied = 0; m_timeout = 0;
        m_owner = 0; m_age = 0; m_rr = 0; m_addr = '0; m_acc = '0;
        forever begin
            @(negedge clk);
            exp_ready = '0;
            exp_rsp   = '0;
            found     = 0;
            pick      = 0;
            if (!m_active) begin
                for (int k = 0; k < NC; k++) begin
                    c = (m_rr + k) % NC;
                    if (req_valid_i[c] && !found) begin
                        exp_ready[c] = 1'b1;
                        found = 1;
                        pick  = c;
                    end
                end
            end else if (m_resolved) begin
                exp_rsp[m_owner] = 1'b1;
            end
            if (mon_en) begin
                check("m_req_ready", 64'(req_ready_o), 64'(exp_ready));
                check("m_rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
                check("m_rsp_denied", 64'(rsp_denied_o), 64'(m_active && m_resolved && m_denied));
                check("m_rsp_timeout", 64'(rsp_timeout_o), 64'(m_active && m_resolved && m_timeout));
                check("m_chk_valid", 64'(chk_valid_o), 64'(m_active && m_age == 1));
                check("m_chk_addr", 64'(chk_addr_o), 64'(m_addr));
                check("m_chk_access", 64'(chk_access_o), 64'(m_acc));
                check("m_chk_rrid", 64'(chk_rrid_o), 64'(m_owner));
                check("m_busy", 64'(busy_o), 64'(m_active));
            end
            if (rst) begin
                m_active = 0; m_resolved = 0; m_denied = 0; m_timeout = 0;
                m_owner = 0; m_age = 0; m_rr = 0; m_addr = '0; m_acc = '0;
            end else if (!m_active) begin
                if (found) begin
                    m_active   = 1;
                    m_resolved = 0;
                    m_age      = 1;
                    m_owner    = pick;
                    m_addr     = req_addr_i[pick*AW +: AW];
                    m_acc      = req_access_i[pick*2 +: 2];
                end
            end else if (!m_resolved) begin
                if (m_age >= 2) begin
                    if (chk_done_i) begin
                        m_resolved = 1; m_denied = chk_denied_i; m_timeout = 0;
                    end else if (m_age - 2 == TO - 1) begin
                        m_resolved = 1; m_denied = 1; m_timeout = 1;
                    end
                end
                m_age++;
            end else if (rsp_ack_i[m_owner]) begin
                m_active = 0;
                m_rr     = (m_owner + 1) % NC;
            end
        end
    end

    // Checker and channel responder: done a fixed delay after chk_valid, ack after N held cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_valid_o) done_timer = done_delay;
            if (rsp_valid_o != '0) resp_cycles++;
            else resp_cycles = 0;
            next();
            chk_done_i   = 1'b0;
            chk_denied_i = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) begin
                    chk_done_i   = 1'b1;
                    chk_denied_i = done_denied;
                end
            end
            rsp_ack_i = (resp_cycles >= ack_delay) ? '1 : '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        next();
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_chk_valid", 64'(chk_valid_o), 64'd0);
        check("rst_chk_addr", 64'(chk_addr_o), 64'd0);
        check("rst_chk_rrid", 64'(chk_rrid_o), 64'd0);
        next();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy_o) ok = 1;
            else next();
        end
        if (!ok) check("wait_idle_timeout", 64'd1, 64'd0);
        next();
    endtask

    task automatic request(input int ch, input logic [AW-1:0] addr, input logic [1:0] acc);
        bit ok;
        ok = 0;
        req_addr_i[ch*AW +: AW] = addr;
        req_access_i[ch*2 +: 2] = acc;
        req_valid_i[ch] = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_o[ch]) ok = 1;
            next();
        end
        req_valid_i[ch] = 1'b0;
        if (!ok) check("request_timeout", 64'd1, 64'd0);
    endtask

    task automatic cycles_to_rsp(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            next();
            n++;
            @(negedge clk);
            if (rsp_valid_o != '0) break;
        end
    endtask

    initial begin
        int rr_q[$];
        int cy_q[$];
        int cyc, n, held, bad;
        bit got;

        do_reset();

        // Single read from ch0, checker answers 3 cycles after the issue pulse.
        done_delay = 3; done_denied = 0; ack_delay = 0;
        req_addr_i[0 +: AW] = 34'h0_1000_0000;
        req_access_i[1:0]   = 2'b01;
        req_valid_i         = 2'b01;
        @(negedge clk);
        check("t1_ready", 64'(req_ready_o), 64'h1);
        next();
        req_valid_i = '0;
        @(negedge clk);
        check("t1_chk_valid", 64'(chk_valid_o), 64'd1);
        check("t1_rrid", 64'(chk_rrid_o), 64'd0);
        check("t1_access", 64'(chk_access_o), 64'h1);
        check("t1_addr", 64'(chk_addr_o), 64'h0_1000_0000);
        for (int i = 0; i < 4; i++) next();
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid_o), 64'h1);
        check("t1_rsp_denied", 64'(rsp_denied_o), 64'd0);
        next();
        @(negedge clk);
        check("t1_rsp_clear", 64'(rsp_valid_o), 64'd0);
        next();

        // Both channels always requesting: strict alternation every 4 cycles.
        do_reset();
        done_delay = 1;
        req_valid_i = 2'b11;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chk_valid_o) begin
                rr_q.push_back(int'(chk_rrid_o));
                cy_q.push_back(cyc);
            end
            next();
            cyc++;
        end
        req_valid_i = '0;
        wait_idle();
        if (rr_q.size() >= 4) begin
            check("t2_g0", 64'(rr_q[0]), 64'd0);
            check("t2_g1", 64'(rr_q[1]), 64'd1);
            check("t2_g2", 64'(rr_q[2]), 64'd0);
            check("t2_g3", 64'(rr_q[3]), 64'd1);
            check("t2_spacing", 64'(cy_q[1] - cy_q[0]), 64'd4);
        end else begin
            check("t2_grant_count", 64'(rr_q.size()), 64'd4);
        end

        // Checker silent: forced deny after 4 wait cycles.
        done_delay = 0;
        request(0, 34'h2_0000_0040, 2'b10);
        cycles_to_rsp(n);
        check("t3_latency", 64'(n), 64'd5);
        check("t3_denied", 64'(rsp_denied_o), 64'd1);
        check("t3_timeout", 64'(rsp_timeout_o), 64'd1);
        wait_idle();

        // Result on the last timeout cycle wins over the timeout.
        done_delay = 4; done_denied = 1;
        request(0, 34'h0_0000_1234, 2'b00);
        cycles_to_rsp(n);
        check("t4_latency", 64'(n), 64'd5);
        check("t4_denied", 64'(rsp_denied_o), 64'd1);
        check("t4_timeout", 64'(rsp_timeout_o), 64'd0);
        wait_idle();

        // Response held 10 extra cycles while ch1 waits.
        do_reset();
        done_delay = 1; done_denied = 1; ack_delay = 10;
        request(0, 34'h0_0000_8000, 2'b01);
        req_addr_i[AW +: AW] = 34'h1_2345_6780;
        req_access_i[3:2]    = 2'b10;
        req_valid_i[1]       = 1'b1;
        held = 0; bad = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid_o == 2'b01) begin
                held++;
                if (!rsp_denied_o || rsp_timeout_o || req_ready_o != '0) bad++;
            end
            if (req_ready_o == 2'b10) got = 1;
            next();
        end
        req_valid_i = '0;
        check("t5_held", 64'(held), 64'd11);
        check("t5_unstable", 64'(bad), 64'd0);
        check("t5_ch1_granted", 64'(got), 64'd1);
        @(negedge clk);
        check("t5_rrid", 64'(chk_rrid_o), 64'd1);
        wait_idle();
        ack_delay = 0;

        // Reset while waiting; the late result must be ignored.
        done_delay = 3; done_denied = 0;
        request(0, 34'h0_0000_0100, 2'b01);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid_o != '0 || busy_o) bad++;
            next();
        end
        check("t6_quiet_after_rst", 64'(bad), 64'd0);
        request(1, 34'h3_FFFF_FFFF, 2'b11);
        @(negedge clk);
        check("t6_rrid", 64'(chk_rrid_o), 64'd1);
        check("t6_access", 64'(chk_access_o), 64'h3);
        check("t6_addr", 64'(chk_addr_o), 64'h3_FFFF_FFFF);
        wait_idle();
        req_valid_i = 2'b11;
        @(negedge clk);
        check("t6_rr_after_ch1", 64'(req_ready_o), 64'h1);
        next();
        req_valid_i = '0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iopmp_check_arbiter.md
Name: iopmp_check_arbiter

Overview:
Shares one IOPMP permission checker among NumChan TL-UL request-handler channels. Each channel presents a check request (address, access type). The block round-robin arbitrates, issues one check at a time to the checker, and waits for the result, bounded by a timeout. It then returns a held permit/deny response to the originating channel. It sits between the per-channel request handlers and the single IOPMP rule-matching engine.

Parameters:
NumChan, 2, number of requesting channels (2..8)
AddrWidth, 34, check address width
RridWidth, 8, RRID width driven to checker (RRID = channel index, zero-extended)
TimeoutCycles, 255, max WAIT cycles before forced deny (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid_i  in  NumChan  per-channel check request
req_ready_o  out  NumChan  per-channel request accepted (one-hot or zero)
req_addr_i  in  NumChan*AddrWidth  per-channel address, channel c at [c*AddrWidth +: AddrWidth]
req_access_i  in  NumChan*2  per-channel access, 2'b01 read, 2'b10 write
rsp_valid_o  out  NumChan  result valid to channel (one-hot or zero)
rsp_denied_o  out  1  result: 1 = denied
rsp_timeout_o  out  1  result produced by timeout
rsp_ack_i  in  NumChan  channel consumes result
chk_valid_o  out  1  issue check to checker (single-cycle pulse)
chk_addr_o  out  AddrWidth  latched address
chk_access_o  out  2  latched access
chk_rrid_o  out  RridWidth  granted channel index
chk_done_i  in  1  checker result valid
chk_denied_i  in  1  checker result, valid with chk_done_i
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0. All outputs 0: req_ready_o, rsp_valid_o, rsp_denied_o, rsp_timeout_o, chk_valid_o, chk_addr_o, chk_access_o, chk_rrid_o, busy_o. Timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i, grant = first set bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo NumChan.
  - req_ready_o[grant]=1 combinationally in the same cycle.
  - Latch addr/access/grant; next state ISSUE.
  - No valid: stay IDLE, req_ready_o=0.
- ISSUE:
  - chk_valid_o=1 for exactly this cycle, with latched chk_addr_o/chk_access_o/chk_rrid_o.
  - Counter cleared; next state WAIT.
  - chk_addr_o/chk_access_o/chk_rrid_o hold their values through WAIT and RESP.
- WAIT:
  - Counter increments each cycle.
  - chk_done_i=1: latch denied=chk_denied_i, timeout=0, go RESP.
  - Else if counter == TimeoutCycles-1: denied=1, timeout=1, go RESP.
  - chk_done_i on the timeout cycle: done wins, timeout=0.
- RESP:
  - rsp_valid_o[grant]=1; rsp_denied_o and rsp_timeout_o held stable until rsp_ack_i[grant]=1.
  - On ack: rr_ptr=(grant+1) mod NumChan, go IDLE. rsp_valid_o drops the next cycle.
  - rsp_ack_i on non-granted bits ignored.
- chk_done_i outside WAIT (ISSUE, RESP, IDLE): ignored, no state change.
- Latency: accept at cycle T, chk_valid_o at T+1, earliest done at T+2, rsp_valid_o at T+3. Best-case back-to-back throughput is one check per 4 cycles (ack in the first RESP cycle).
- Fairness: a channel holding req_valid_i is granted within NumChan arbitration rounds.
- Access encoding is passed through unmodified; 2'b00 and 2'b11 are forwarded as-is.
- Reset mid-operation: immediate return to IDLE, in-flight check discarded, no rsp_valid_o generated. A late chk_done_i is ignored.
- rsp_denied_o and rsp_timeout_o are 0 whenever rsp_valid_o is all-zero.

Test Plan:
- NumChan=2, only ch0 valid, addr 0x0_1000_0000, read; checker done 3 cycles after chk_valid with denied=0 -> req_ready_o=01 at T, chk_valid T+1, chk_rrid=0, chk_access=01, rsp_valid_o=01 with denied=0 at T+5, cleared the cycle after ack.
- ch0 and ch1 both valid continuously, done after 1 cycle, ack immediately -> grants alternate 0,1,0,1; chk_rrid sequence 0,1,0,1.
- Checker never responds, TimeoutCycles=4 -> rsp_valid after 4 WAIT cycles with denied=1, timeout=1.
- chk_done_i=1 with denied=1 on the last timeout cycle -> denied=1, timeout=0.
- Response held: ack delayed 10 cycles while ch1 requests -> rsp_valid and denied stable, req_ready_o stays 0 until ack, then ch1 granted.
- rst asserted in WAIT, then chk_done_i pulses -> outputs 0, state IDLE, no rsp_valid; next ch1 request granted first only if ch0 idle (rr_ptr=0).
